// File: rtl/operand_bypass_unit.sv
`default_nettype none
// ============================================================================
// Module      : operand_bypass_unit
// Description : EX/MEM/WB destination-tag pipeline, ALU operand bypass
//               selection and load-use / RAW stall generation.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_bypass_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FORWARD_EN     = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rs,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rt,
    input  logic [DATA_WIDTH-1:0]     issue_rs_data,
    input  logic [DATA_WIDTH-1:0]     issue_rt_data,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
    input  logic                      issue_reg_write,
    input  logic                      issue_mem_read,
    input  logic                      flush,
    input  logic [DATA_WIDTH-1:0]     mem_stage_data,
    input  logic [DATA_WIDTH-1:0]     wb_stage_data,
    output logic                      stall,
    output logic [DATA_WIDTH-1:0]     operand_a,
    output logic [DATA_WIDTH-1:0]     operand_b,
    output logic [1:0]                a_sel,
    output logic [1:0]                b_sel,
    output logic                      ex_valid,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd
);

    logic                      r_ex_valid, r_ex_rw, r_ex_mr;
    logic [REG_ADDR_WIDTH-1:0] r_ex_rd, r_ex_rs, r_ex_rt;
    logic [DATA_WIDTH-1:0]     r_opa, r_opb;
    logic                      r_mem_valid, r_mem_rw, r_mem_mr;
    logic [REG_ADDR_WIDTH-1:0] r_mem_rd;
    logic                      r_wb_valid, r_wb_rw;
    logic [REG_ADDR_WIDTH-1:0] r_wb_rd;

    logic                      w_hazard;
    logic                      w_issue_go;
    logic [DATA_WIDTH-1:0]     w_opa_next, w_opb_next;

    // Register 0 is hard-wired zero, so it never counts as produced.
    function automatic logic produces(input logic v, input logic rw,
                                      input logic [REG_ADDR_WIDTH-1:0] rd,
                                      input logic [REG_ADDR_WIDTH-1:0] r);
        return v && rw && (rd == r) && (r != '0);
    endfunction

    assign stall      = issue_valid && !flush && w_hazard;
    assign w_issue_go = issue_valid && !flush && !stall;
    assign ex_valid   = r_ex_valid;
    assign ex_rd      = r_ex_rd;

    generate
        if (FORWARD_EN != 0) begin : g_fwd
            assign w_hazard = r_ex_mr &&
                              (produces(r_ex_valid, r_ex_rw, r_ex_rd, issue_rs) ||
                               produces(r_ex_valid, r_ex_rw, r_ex_rd, issue_rt));

            // WB writes the register file at the end of its cycle, so the
            // value read in ID this cycle is stale and must be taken from WB.
            assign w_opa_next = produces(r_wb_valid, r_wb_rw, r_wb_rd, issue_rs) ?
                                wb_stage_data : issue_rs_data;
            assign w_opb_next = produces(r_wb_valid, r_wb_rw, r_wb_rd, issue_rt) ?
                                wb_stage_data : issue_rt_data;

            always_comb begin
                a_sel = 2'b00;
                b_sel = 2'b00;
                if (r_ex_valid) begin
                    if (produces(r_mem_valid, r_mem_rw, r_mem_rd, r_ex_rs) && !r_mem_mr)
                        a_sel = 2'b01;
                    else if (produces(r_wb_valid, r_wb_rw, r_wb_rd, r_ex_rs))
                        a_sel = 2'b10;
                    if (produces(r_mem_valid, r_mem_rw, r_mem_rd, r_ex_rt) && !r_mem_mr)
                        b_sel = 2'b01;
                    else if (produces(r_wb_valid, r_wb_rw, r_wb_rd, r_ex_rt))
                        b_sel = 2'b10;
                end
            end

            assign operand_a = (a_sel == 2'b01) ? mem_stage_data :
                               (a_sel == 2'b10) ? wb_stage_data  : r_opa;
            assign operand_b = (b_sel == 2'b01) ? mem_stage_data :
                               (b_sel == 2'b10) ? wb_stage_data  : r_opb;
        end else begin : g_intlk
            assign w_hazard =
                produces(r_ex_valid,  r_ex_rw,  r_ex_rd,  issue_rs) ||
                produces(r_ex_valid,  r_ex_rw,  r_ex_rd,  issue_rt) ||
                produces(r_mem_valid, r_mem_rw, r_mem_rd, issue_rs) ||
                produces(r_mem_valid, r_mem_rw, r_mem_rd, issue_rt) ||
                produces(r_wb_valid,  r_wb_rw,  r_wb_rd,  issue_rs) ||
                produces(r_wb_valid,  r_wb_rw,  r_wb_rd,  issue_rt);

            assign w_opa_next = issue_rs_data;
            assign w_opb_next = issue_rt_data;
            assign a_sel      = 2'b00;
            assign b_sel      = 2'b00;
            assign operand_a  = r_opa;
            assign operand_b  = r_opb;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex_valid  <= 1'b0;
            r_ex_rw     <= 1'b0;
            r_ex_mr     <= 1'b0;
            r_ex_rd     <= '0;
            r_ex_rs     <= '0;
            r_ex_rt     <= '0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_mem_valid <= 1'b0;
            r_mem_rw    <= 1'b0;
            r_mem_mr    <= 1'b0;
            r_mem_rd    <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_rw     <= 1'b0;
            r_wb_rd     <= '0;
        end else begin
            r_wb_valid  <= r_mem_valid;
            r_wb_rw     <= r_mem_rw;
            r_wb_rd     <= r_mem_rd;
            r_mem_valid <= r_ex_valid;
            r_mem_rw    <= r_ex_rw;
            r_mem_mr    <= r_ex_mr;
            r_mem_rd    <= r_ex_rd;
            r_ex_valid  <= w_issue_go;
            r_ex_rw     <= issue_reg_write;
            r_ex_mr     <= issue_mem_read;
            r_ex_rd     <= issue_rd;
            r_ex_rs     <= issue_rs;
            r_ex_rt     <= issue_rt;
            r_opa       <= w_opa_next;
            r_opb       <= w_opb_next;
        end
    end

endmodule
`default_nettype wire
